// File: rtl/sobel_pkg.sv
// Shared types, kernel coefficients and width helpers for the Sobel stream engine.
package sobel_pkg;

  typedef enum logic {
    MODE_MAG    = 1'b0,
    MODE_THRESH = 1'b1
  } mode_t;

  localparam int K_EDGE   = 1;
  localparam int K_CENTER = 2;

  function automatic int grad_width(input int pixel_bits);
    return pixel_bits + 3;
  endfunction

  function automatic int mag_width(input int pixel_bits);
    return pixel_bits + 4;
  endfunction

endpackage

// File: rtl/sobel_stream_engine_if.sv
// Pixel stream in/out handshake plus per-frame result controls.
interface sobel_stream_engine_if
  import sobel_pkg::*;
#(
  parameter int PIXEL_BITS = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PIXEL_BITS-1:0]   in_pixel;
  logic                    in_sof;
  mode_t                   mode;
  logic [PIXEL_BITS+3:0]   threshold;
  logic                    out_valid;
  logic                    out_ready;
  logic [PIXEL_BITS-1:0]   out_pixel;
  logic                    out_sof;
  logic                    out_eol;

  modport master (
    output in_valid, in_pixel, in_sof, mode, threshold, out_ready,
    input  in_ready, out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, mode, threshold, out_ready,
    output in_ready, out_valid, out_pixel, out_sof, out_eol
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: combinational read and clocked write at the same column address.
module sobel_line_buffer #(
  parameter int  DEPTH = 400,
  parameter int  WIDTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are not reset; a frame always writes a column before reading it back.
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel: two line buffers, a sliding window and one output register.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int PIXEL_BITS = 4,
  parameter int MAG_SHIFT  = 2
) (
  input logic                  clk,
  input logic                  n_rst,
  sobel_stream_engine_if.slave s
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = grad_width(PIXEL_BITS);
  localparam int MW = mag_width(PIXEL_BITS);

  logic [CW-1:0]         col_q, cur_col;
  logic [RW-1:0]         row_q, cur_row;
  logic                  accept, emit, col_last, row_last;
  logic [PIXEL_BITS-1:0] lb_a_rd, lb_b_rd;
  logic [PIXEL_BITS-1:0] win  [3][3];
  logic [PIXEL_BITS-1:0] nwin [3][3];
  logic [GW-1:0]         e [3][3];
  logic [GW-1:0]         gx, gy, ax, ay;
  logic [MW-1:0]         mag, mag_sh;
  logic [PIXEL_BITS-1:0] result;
  logic                  out_valid_q, out_sof_q, out_eol_q;
  logic [PIXEL_BITS-1:0] out_pixel_q;

  assign s.in_ready  = !out_valid_q || s.out_ready;
  assign accept      = s.in_valid && s.in_ready;
  assign cur_col     = s.in_sof ? '0 : col_q;
  assign cur_row     = s.in_sof ? '0 : row_q;
  assign col_last    = (cur_col == CW'(IMG_WIDTH - 1));
  assign row_last    = (cur_row == RW'(IMG_HEIGHT - 1));
  assign emit        = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_BITS)) u_lb_a (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (cur_col),
    .wr_data (s.in_pixel),
    .rd_data (lb_a_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_BITS)) u_lb_b (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (cur_col),
    .wr_data (lb_a_rd),
    .rd_data (lb_b_rd)
  );

  // Window as it will look after this accept: shifted left with the new column on the right.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nwin[i][0] = win[i][1];
      nwin[i][1] = win[i][2];
    end
    nwin[0][2] = lb_b_rd;
    nwin[1][2] = lb_a_rd;
    nwin[2][2] = s.in_pixel;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e[i][j] = GW'(nwin[i][j]);
  end

  always_comb begin
    gx = (e[0][2] * GW'(K_EDGE) + e[1][2] * GW'(K_CENTER) + e[2][2] * GW'(K_EDGE))
       - (e[0][0] * GW'(K_EDGE) + e[1][0] * GW'(K_CENTER) + e[2][0] * GW'(K_EDGE));
    gy = (e[2][0] * GW'(K_EDGE) + e[2][1] * GW'(K_CENTER) + e[2][2] * GW'(K_EDGE))
       - (e[0][0] * GW'(K_EDGE) + e[0][1] * GW'(K_CENTER) + e[0][2] * GW'(K_EDGE));
    ax     = gx[GW-1] ? -gx : gx;
    ay     = gy[GW-1] ? -gy : gy;
    mag    = MW'(ax) + MW'(ay);
    mag_sh = mag >> MAG_SHIFT;
    if (s.mode == MODE_THRESH)
      result = (mag >= s.threshold) ? '1 : '0;
    else if (mag_sh > MW'((1 << PIXEL_BITS) - 1))
      result = '1;
    else
      result = mag_sh[PIXEL_BITS-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q <= '0;
      row_q <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
      win <= nwin;
    end
  end

  // A stalled register blocks accepts, so a load can only happen when it is free or draining.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_pixel_q <= result;
      out_sof_q   <= (cur_row == RW'(2)) && (cur_col == CW'(2));
      out_eol_q   <= col_last;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_pixel = out_pixel_q;
  assign s.out_sof   = out_sof_q;
  assign s.out_eol   = out_eol_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine on an 8x6 frame with 4-bit pixels.
module tb_sobel_stream_engine;
  import sobel_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic tb_HCLK;
  logic n_rst;

  sobel_stream_engine_if #(.PIXEL_BITS(4)) bus ();

  sobel_stream_engine #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(4), .MAG_SHIFT(2)
  ) dut (
    .clk   (tb_HCLK),
    .n_rst (n_rst),
    .s     (bus)
  );

  initial tb_HCLK = 1'b0;
  always #5 tb_HCLK = ~tb_HCLK;

  int         total = 0;
  int         bad   = 0;
  int         rcv_cnt;
  int         first_sof;
  int         img [H][W];
  int         m_row, m_col;
  mode_t      cur_mode;
  int         cur_thr;
  logic [5:0] exp_q [$];

  function automatic logic [3:0] model_px(input int r, input int c);
    int p [3][3];
    int gx, gy, mag, v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j];
    gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (cur_mode == MODE_THRESH) v = (mag >= cur_thr) ? 15 : 0;
    else begin
      v = mag >> 2;
      if (v > 15) v = 15;
    end
    return 4'(v);
  endfunction

  task automatic monitor();
    logic [5:0] got, exp;
    forever begin
      @(negedge tb_HCLK);
      if (n_rst && bus.out_valid && bus.out_ready) begin
        got = {bus.out_pixel, bus.out_sof, bus.out_eol};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got px=%h sof=%b eol=%b expected none", got[5:2], got[1], got[0]);
        end else begin
          exp = exp_q.pop_front();
          if (rcv_cnt == 0) first_sof = got[1];
          rcv_cnt++;
          if (got !== exp) begin
            bad++;
            $display("FAIL out_stream #%0d got px=%h sof=%b eol=%b expected px=%h sof=%b eol=%b",
                     rcv_cnt, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
          end
        end
      end
    end
  endtask

  task automatic send_px(input bit sof);
    int  er, ec, guard;
    bit  done;
    er = sof ? 0 : m_row;
    ec = sof ? 0 : m_col;
    bus.in_valid  = 1'b1;
    bus.in_sof    = sof;
    bus.in_pixel  = 4'(img[er][ec]);
    bus.mode      = cur_mode;
    bus.threshold = 8'(cur_thr);
    done  = 0;
    guard = 0;
    while (!done) begin
      @(negedge tb_HCLK);
      if (bus.in_ready) begin
        done = 1;
        if (er >= 2 && ec >= 2)
          exp_q.push_back({model_px(er, ec), (er == 2 && ec == 2) ? 1'b1 : 1'b0, (ec == W-1) ? 1'b1 : 1'b0});
        if (ec == W-1) begin
          m_col = 0;
          m_row = (er == H-1) ? 0 : er + 1;
        end else begin
          m_col = ec + 1;
          m_row = er;
        end
      end else if (++guard > 100) begin
        total++;
        bad++;
        $display("FAIL accept_timeout got in_ready=0 expected 1 within 100 cycles");
        done = 1;
      end
      @(posedge tb_HCLK);
      #1;
    end
    bus.in_sof = 1'b0;
  endtask

  task automatic send_frame(input int n_px);
    for (int k = 0; k < n_px; k++) send_px(k == 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 50) begin
      @(posedge tb_HCLK);
      #1;
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic start_test(input mode_t md, input int thr);
    cur_mode  = md;
    cur_thr   = thr;
    rcv_cnt   = 0;
    first_sof = 0;
  endtask

  task automatic check_count(input string name);
    total++;
    if (rcv_cnt !== (H-2)*(W-2)) begin
      bad++;
      $display("FAIL %s_count got %0d expected %0d", name, rcv_cnt, (H-2)*(W-2));
    end
    total++;
    if (first_sof !== 1) begin
      bad++;
      $display("FAIL %s_first_sof got %0d expected 1", name, first_sof);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_step();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 15 : 0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.out_valid, bus.out_pixel, bus.out_sof, bus.out_eol, bus.in_ready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL reset_state got ov=%b px=%h sof=%b eol=%b ir=%b expected 0 0 0 0 1",
               bus.out_valid, bus.out_pixel, bus.out_sof, bus.out_eol, bus.in_ready);
    end
  endtask

  task automatic test_constant();
    fill_const(9);
    start_test(MODE_MAG, 0);
    send_frame(W*H);
    drain();
    check_count("constant");
  endtask

  task automatic test_step_mag();
    fill_step();
    start_test(MODE_MAG, 0);
    send_frame(W*H);
    drain();
    check_count("step_mag");
  endtask

  task automatic test_step_thresh();
    fill_step();
    start_test(MODE_THRESH, 61);
    send_frame(W*H);
    drain();
    check_count("thresh61");
    start_test(MODE_THRESH, 60);
    send_frame(W*H);
    drain();
    check_count("thresh60");
  endtask

  task automatic test_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 15));
    start_test(MODE_MAG, 0);
    send_frame(W*H);
    drain();
    check_count("random_mag");
    start_test(MODE_THRESH, int'($urandom_range(10, 90)));
    send_frame(W*H);
    drain();
    check_count("random_thresh");
  endtask

  task automatic test_backpressure();
    fill_step();
    start_test(MODE_MAG, 0);
    fork
      send_frame(W*H);
      begin
        logic [3:0] held;
        int guard = 0;
        while (!bus.out_valid && guard < 200) begin
          @(posedge tb_HCLK);
          #1;
          guard++;
        end
        bus.out_ready = 1'b0;
        held = bus.out_pixel;
        repeat (5) begin
          @(negedge tb_HCLK);
          total++;
          if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pixel !== held) begin
            bad++;
            $display("FAIL stall got ir=%b ov=%b px=%h expected ir=0 ov=1 px=%h",
                     bus.in_ready, bus.out_valid, bus.out_pixel, held);
          end
        end
        @(posedge tb_HCLK);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check_count("backpressure");
  endtask

  task automatic test_sof_restart();
    fill_step();
    start_test(MODE_MAG, 0);
    send_frame(13);
    send_frame(W*H);
    drain();
    check_count("sof_restart");
  endtask

  task automatic test_reset_midstream();
    fill_step();
    start_test(MODE_MAG, 0);
    send_frame(30);
    bus.out_ready = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_pixel !== 4'h0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_midstream got ov=%b px=%h ir=%b expected 0 0 1",
               bus.out_valid, bus.out_pixel, bus.in_ready);
    end
    n_rst = 1'b1;
    exp_q.delete();
    bus.out_ready = 1'b1;
    m_row = 0;
    m_col = 0;
    @(posedge tb_HCLK);
    #1;
    start_test(MODE_MAG, 0);
    send_frame(W*H);
    drain();
    check_count("after_reset");
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.in_sof    = 1'b0;
    bus.mode      = MODE_MAG;
    bus.threshold = '0;
    bus.out_ready = 1'b1;
    m_row         = 0;
    m_col         = 0;
    rcv_cnt       = 0;
    first_sof     = 0;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
      end
    join_none
    repeat (3) @(posedge tb_HCLK);
    #1;
    test_reset();
    n_rst = 1'b1;
    @(posedge tb_HCLK);
    #1;
    test_constant();
    test_step_mag();
    test_step_thresh();
    test_backpressure();
    test_sof_restart();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_stream_engine.md
Name: sobel_stream_engine

Overview:
Parametrised streaming successor to the AHB-fed 4x4-window Sobel core. Accepts one pixel per cycle in raster order over a valid/ready interface and keeps two internal line buffers. Produces one gradient pixel per interior image position, either as scaled magnitude or as a thresholded binary edge map. Sits between the frame-ingest DMA and the output frame writer.

Parameters:
IMG_WIDTH, 400, pixels per line (>=3)
IMG_HEIGHT, 300, lines per frame (>=3)
PIXEL_BITS, 4, input/output pixel width
MAG_SHIFT, 2, right shift applied to magnitude in scaled mode

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  engine can accept pixel
in_pixel  in  PIXEL_BITS  input pixel, raster order
in_sof  in  1  qualifies in_pixel as frame position (0,0)
mode  in  1  0 = scaled magnitude, 1 = binary threshold
threshold  in  PIXEL_BITS+4  edge threshold for mode 1
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_pixel  out  PIXEL_BITS  gradient result
out_sof  out  1  output is interior position (1,1)
out_eol  out  1  output is last interior column (W-2)

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0 except in_ready, which is 1 (derived). Row/col counters and the 3x3 window registers are 0. Line-buffer RAM is not reset; its contents are never used before being written in the current frame.
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready, i.e. a single output register with pass-through readiness.
- Output transfer = out_valid && out_ready. out_* are held stable while out_valid && !out_ready.
- Position counters (row, col) point at the pixel being accepted.
  - in_sof on an accept forces the position to (0,0).
  - After an accept, col increments. At col==IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0.
  - in_sof mid-frame abandons the partial frame. A pending output register is still delivered.
- Line buffers: lb_a holds row r-1 and lb_b holds row r-2, indexed by col. On accept at col c:
  - new window column = {lb_b[c], lb_a[c], in_pixel}
  - lb_b[c] <= lb_a[c]; lb_a[c] <= in_pixel
  - the window shifts one column left.
- Emission: an accept at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1). The output register loads on the next clk edge, so out_valid rises one cycle after the accept (latency 1).
  - out_sof = (r==2 && c==2)
  - out_eol = (c==IMG_WIDTH-1)
  - Frame output count is (IMG_HEIGHT-2)*(IMG_WIDTH-2). Border pixels are never emitted.
  - Window columns from the previous line are not mixed in at c<2, because emission is inhibited there.
- Arithmetic (unsigned pixels, signed intermediates of PIXEL_BITS+3 bits):
  - Gx = (p02+2*p12+p22) - (p00+2*p10+p20)
  - Gy = (p20+2*p21+p22) - (p00+2*p01+p02)
  - mag = |Gx|+|Gy|, unsigned PIXEL_BITS+4 bits, no overflow possible.
  - mode 0: out = min(mag>>MAG_SHIFT, 2^PIXEL_BITS-1), saturating.
  - mode 1: out = (mag >= threshold) ? all ones : 0.
  - mode and threshold are sampled on the emitting accept.
- Simultaneous output transfer and new load in the same cycle: the register reloads and out_valid stays 1, giving full throughput of 1 pixel/cycle.

Decomposition:
- sobel_pkg holds:
  - typedef mode_t (MODE_MAG=0, MODE_THRESH=1)
  - Sobel kernel coefficient constants
  - width helper functions for the gradient and magnitude widths
- Sub-module sobel_line_buffer (depth IMG_WIDTH, width PIXEL_BITS, one read and one write per accept, same address) is instantiated twice.

Test Plan:
- Reset mid-stream (n_rst low for 1 ns between edges) -> out_valid=0, out_pixel=0, in_ready=1 immediately; the next in_sof frame behaves as fresh.
- Constant image of 0x9 (W=8, H=6, mode 0) -> exactly 24 outputs, all 0x0; out_sof on the 1st output; out_eol on the 6th, 12th, 18th and 24th.
- Vertical step (cols 0-3 = 0x0, cols 4-7 = 0xF, W=8, H=6, MAG_SHIFT=2, mode 0) -> centre cols 3 and 4 give mag 60, out 0xF; all other centre cols give 0x0.
- Same step image, mode 1: threshold=61 -> all outputs 0x0; threshold=60 -> 0xF at cols 3 and 4.
- Backpressure: out_ready held 0 for 5 cycles after the first out_valid -> in_ready=0, out_pixel stable, no pixel lost; the output sequence is identical to the no-stall run.
- in_sof reasserted after 13 pixels -> counters restart, and the output count for the new frame equals 24 with out_sof on its first output.
